// File: rtl/axi_dw_upsizer.sv
// AXI4 data-width upsizer: each narrow beat is forwarded as one narrow-sized beat on the wide bus,
// with W steered into and R extracted from the byte lanes selected by the running beat address.
package axi_dw_upsizer_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [7:0]  user;
  } aw_chan_t;
  typedef aw_chan_t ar_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [7:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [7:0]  user;
  } slv_w_chan_t;
  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [7:0]   user;
  } mst_w_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  user;
  } slv_r_chan_t;
  typedef struct packed {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [7:0]   user;
  } mst_r_chan_t;
endpackage

module axi_dw_upsizer #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 256,
  parameter int unsigned UserWidth    = 8,
  parameter type aw_chan_t    = axi_dw_upsizer_pkg::aw_chan_t,
  parameter type ar_chan_t    = axi_dw_upsizer_pkg::ar_chan_t,
  parameter type b_chan_t     = axi_dw_upsizer_pkg::b_chan_t,
  parameter type slv_w_chan_t = axi_dw_upsizer_pkg::slv_w_chan_t,
  parameter type mst_w_chan_t = axi_dw_upsizer_pkg::mst_w_chan_t,
  parameter type slv_r_chan_t = axi_dw_upsizer_pkg::slv_r_chan_t,
  parameter type mst_r_chan_t = axi_dw_upsizer_pkg::mst_r_chan_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  aw_chan_t    slv_aw_i,
  input  logic        slv_aw_valid_i,
  output logic        slv_aw_ready_o,
  input  slv_w_chan_t slv_w_i,
  input  logic        slv_w_valid_i,
  output logic        slv_w_ready_o,
  output b_chan_t     slv_b_o,
  output logic        slv_b_valid_o,
  input  logic        slv_b_ready_i,
  input  ar_chan_t    slv_ar_i,
  input  logic        slv_ar_valid_i,
  output logic        slv_ar_ready_o,
  output slv_r_chan_t slv_r_o,
  output logic        slv_r_valid_o,
  input  logic        slv_r_ready_i,
  output aw_chan_t    mst_aw_o,
  output logic        mst_aw_valid_o,
  input  logic        mst_aw_ready_i,
  output mst_w_chan_t mst_w_o,
  output logic        mst_w_valid_o,
  input  logic        mst_w_ready_i,
  input  b_chan_t     mst_b_i,
  input  logic        mst_b_valid_i,
  output logic        mst_b_ready_o,
  output ar_chan_t    mst_ar_o,
  output logic        mst_ar_valid_o,
  input  logic        mst_ar_ready_i,
  input  mst_r_chan_t mst_r_i,
  input  logic        mst_r_valid_i,
  output logic        mst_r_ready_o
);

  localparam int unsigned SB        = SlvDataWidth / 8;
  localparam int unsigned MB        = MstDataWidth / 8;
  localparam int unsigned Ratio     = MstDataWidth / SlvDataWidth;
  localparam int unsigned LaneLsb   = $clog2(SB);
  localparam int unsigned LaneWidth = $clog2(Ratio);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

  state_e               wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  aw_chan_t             aw_q, aw_d;
  ar_chan_t             ar_q, ar_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic                 w_pass, w_hs, w_last_hs, r_pass, r_hs, r_last_hs;
  logic [LaneWidth-1:0] w_lane, r_lane;

  // Window mask for WRAP is (len+1)*2^size - 1; the burst is assumed aligned to 2^size.
  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                     input logic [7:0] len,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
    logic [AddrWidth-1:0] incr, nxt, wrap_mask;
    incr      = AddrWidth'(1) << size;
    nxt       = (addr & ~(incr - AddrWidth'(1))) + incr;
    wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~wrap_mask) | (nxt & wrap_mask);
      default: next_addr = nxt;
    endcase
  endfunction

  // W is blocked in drain so the next burst's data cannot use a stale beat address.
  assign w_pass    = (wr_state_q == StAddr) || (wr_state_q == StData);
  assign w_hs      = w_pass && slv_w_valid_i && mst_w_ready_i;
  assign w_last_hs = w_hs && slv_w_i.last;
  assign r_pass    = (rd_state_q == StAddr) || (rd_state_q == StData);
  assign r_hs      = r_pass && mst_r_valid_i && slv_r_ready_i;
  assign r_last_hs = r_hs && mst_r_i.last;
  assign w_lane    = waddr_q[LaneLsb +: LaneWidth];
  assign r_lane    = raddr_q[LaneLsb +: LaneWidth];

  always_comb begin
    wr_state_d     = wr_state_q;
    aw_d           = aw_q;
    waddr_d        = waddr_q;
    slv_aw_ready_o = 1'b0;
    mst_aw_valid_o = 1'b0;
    unique case (wr_state_q)
      StIdle: begin
        slv_aw_ready_o = 1'b1;
        if (slv_aw_valid_i) begin
          aw_d       = slv_aw_i;
          waddr_d    = slv_aw_i.addr;
          wr_state_d = StAddr;
        end
      end
      StAddr: begin
        mst_aw_valid_o = 1'b1;
        if (mst_aw_ready_i) wr_state_d = w_last_hs ? StIdle : StData;
        else if (w_last_hs) wr_state_d = StDrain;
      end
      StData:  if (w_last_hs) wr_state_d = StIdle;
      StDrain: begin
        mst_aw_valid_o = 1'b1;
        if (mst_aw_ready_i) wr_state_d = StIdle;
      end
      default: wr_state_d = StIdle;
    endcase
    if (w_hs) waddr_d = next_addr(waddr_q, aw_q.len, aw_q.size, aw_q.burst);
  end

  always_comb begin
    rd_state_d     = rd_state_q;
    ar_d           = ar_q;
    raddr_d        = raddr_q;
    slv_ar_ready_o = 1'b0;
    mst_ar_valid_o = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        slv_ar_ready_o = 1'b1;
        if (slv_ar_valid_i) begin
          ar_d       = slv_ar_i;
          raddr_d    = slv_ar_i.addr;
          rd_state_d = StAddr;
        end
      end
      StAddr: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) rd_state_d = r_last_hs ? StIdle : StData;
        else if (r_last_hs) rd_state_d = StDrain;
      end
      StData:  if (r_last_hs) rd_state_d = StIdle;
      StDrain: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
    if (r_hs) raddr_d = next_addr(raddr_q, ar_q.len, ar_q.size, ar_q.burst);
  end

  always_comb begin
    mst_w_o       = '0;
    mst_w_o.data  = {Ratio{slv_w_i.data}};
    mst_w_o.strb  = {{(MB - SB){1'b0}}, slv_w_i.strb} << (w_lane * SB);
    mst_w_o.last  = slv_w_i.last;
    mst_w_o.user  = slv_w_i.user;
    mst_w_valid_o = w_pass && slv_w_valid_i;
    slv_w_ready_o = w_pass && mst_w_ready_i;

    slv_r_o       = '0;
    slv_r_o.id    = IdWidth'(mst_r_i.id);
    slv_r_o.data  = mst_r_i.data[r_lane * SlvDataWidth +: SlvDataWidth];
    slv_r_o.resp  = mst_r_i.resp;
    slv_r_o.last  = mst_r_i.last;
    slv_r_o.user  = UserWidth'(mst_r_i.user);
    slv_r_valid_o = r_pass && mst_r_valid_i;
    mst_r_ready_o = r_pass && slv_r_ready_i;
  end

  assign slv_b_o       = mst_b_i;
  assign slv_b_valid_o = mst_b_valid_i;
  assign mst_b_ready_o = slv_b_ready_i;
  assign mst_aw_o      = aw_q;
  assign mst_ar_o      = ar_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= StIdle;
      rd_state_q <= StIdle;
      aw_q       <= '0;
      ar_q       <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_q       <= aw_d;
      ar_q       <= ar_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
    end
  end

endmodule

// File: tb/tb_axi_dw_upsizer.sv
// Self-checking bench for axi_dw_upsizer: scenario tasks with a queue-based scoreboard of the
// expected wide W beats and narrow R beats.
module tb_axi_dw_upsizer;
  import axi_dw_upsizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  aw_chan_t    slv_aw_i, mst_aw_o;
  ar_chan_t    slv_ar_i, mst_ar_o;
  slv_w_chan_t slv_w_i;
  mst_w_chan_t mst_w_o;
  b_chan_t     slv_b_o, mst_b_i;
  slv_r_chan_t slv_r_o;
  mst_r_chan_t mst_r_i;
  logic slv_aw_valid_i, slv_aw_ready_o, slv_w_valid_i, slv_w_ready_o;
  logic slv_b_valid_o, slv_b_ready_i, slv_ar_valid_i, slv_ar_ready_o;
  logic slv_r_valid_o, slv_r_ready_i, mst_aw_valid_o, mst_aw_ready_i;
  logic mst_w_valid_o, mst_w_ready_i, mst_b_valid_i, mst_b_ready_o;
  logic mst_ar_valid_o, mst_ar_ready_i, mst_r_valid_i, mst_r_ready_o;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } w_exp_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  w_exp_t w_q[$];
  r_exp_t r_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_dw_upsizer dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_aw_i(slv_aw_i), .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_w_i(slv_w_i), .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
    .slv_b_o(slv_b_o), .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
    .slv_ar_i(slv_ar_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_r_o(slv_r_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
    .mst_aw_o(mst_aw_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_o(mst_w_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_b_i(mst_b_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
    .mst_ar_o(mst_ar_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_r_i(mst_r_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o)
  );

  // Closed-form address of beat i, independent of any running-address state.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    logic [63:0] incr, win, base;
    incr = 64'd1 << size;
    win  = incr * 64'(len + 1);
    base = a - (a % win);
    case (burst)
      2'b00:   return a;
      2'b10:   return base + ((a - base + incr * 64'(i)) % win);
      default: return (i == 0) ? a : (a & ~(incr - 64'd1)) + incr * 64'(i);
    endcase
  endfunction

  task automatic write_burst(input logic [63:0] addr, input int len, input int size,
                             input logic [1:0] burst, input logic [3:0] id, input int stall);
    aw_chan_t    exp_aw;
    logic [63:0] a;
    logic [31:0] d;
    w_exp_t      e, got;
    exp_aw = '0;
    exp_aw.id = id; exp_aw.addr = addr; exp_aw.len = 8'(len); exp_aw.size = 3'(size);
    exp_aw.burst = burst; exp_aw.cache = 4'h3; exp_aw.user = 8'hA5;
    slv_aw_i = exp_aw;
    slv_aw_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (slv_aw_ready_o !== 1'b1) begin
      errors++; $display("FAIL aw_ready: got %b want 1", slv_aw_ready_o);
    end
    checks++;
    if (mst_aw_valid_o !== 1'b0) begin
      errors++; $display("FAIL aw_same_cycle: mst_aw_valid got %b want 0", mst_aw_valid_o);
    end
    @(posedge clk); #1;
    slv_aw_valid_i = 1'b0;
    slv_aw_i = '0;
    @(negedge clk);
    checks++;
    if ({mst_aw_valid_o, mst_aw_o} !== {1'b1, exp_aw}) begin
      errors++; $display("FAIL mst_aw: got %b/%h want 1/%h", mst_aw_valid_o, mst_aw_o, exp_aw);
    end
    mst_aw_ready_i = 1'b1;
    @(posedge clk); #1;
    mst_aw_ready_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      d = 32'hDEADBEEF ^ (32'h11111111 * 32'(i));
      e.data = {8{d}};
      e.strb = 32'hF << (32'(a[4:2]) * 4);
      e.last = (i == len);
      w_q.push_back(e);
      slv_w_i = '0;
      slv_w_i.data = d; slv_w_i.strb = 4'hF; slv_w_i.last = (i == len); slv_w_i.user = 8'(i);
      slv_w_valid_i = 1'b1;
      if (i == 0) begin
        for (int k = 0; k < stall; k++) begin
          mst_w_ready_i = 1'b0;
          @(negedge clk);
          checks++;
          if ({slv_w_ready_o, mst_w_valid_o} !== 2'b01) begin
            errors++;
            $display("FAIL w_stall cyc %0d: ready/valid got %b%b want 01", k, slv_w_ready_o,
                     mst_w_valid_o);
          end
          @(posedge clk); #1;
        end
      end
      mst_w_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (slv_aw_ready_o !== 1'b0) begin
        errors++; $display("FAIL aw_blocked beat %0d: got %b want 0", i, slv_aw_ready_o);
      end
      checks++;
      if ({mst_w_valid_o, slv_w_ready_o} !== 2'b11) begin
        errors++;
        $display("FAIL w_handshake beat %0d: got %b%b want 11", i, mst_w_valid_o, slv_w_ready_o);
      end
      got = {mst_w_o.data, mst_w_o.strb, mst_w_o.last};
      e = w_q.pop_front();
      checks++;
      if (got !== e || mst_w_o.user !== 8'(i)) begin
        errors++;
        $display("FAIL w_beat %0d: got strb=%h last=%b data=%h want strb=%h last=%b data=%h", i,
                 got.strb, got.last, got.data, e.strb, e.last, e.data);
      end
      @(posedge clk); #1;
    end
    slv_w_valid_i = 1'b0;
    mst_w_ready_i = 1'b0;
    mst_b_i = '0;
    mst_b_i.id = id; mst_b_i.resp = 2'b00; mst_b_i.user = 8'h3C;
    mst_b_valid_i = 1'b1;
    slv_b_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({slv_b_valid_o, mst_b_ready_o, slv_b_o.id, slv_b_o.resp} !== {1'b1, 1'b1, id, 2'b00}) begin
      errors++;
      $display("FAIL b_path: got v=%b r=%b id=%h resp=%h want 1 1 %h 0", slv_b_valid_o,
               mst_b_ready_o, slv_b_o.id, slv_b_o.resp, id);
    end
    checks++;
    if (slv_aw_ready_o !== 1'b1) begin
      errors++; $display("FAIL aw_ready_after_last: got %b want 1", slv_aw_ready_o);
    end
    @(posedge clk); #1;
    mst_b_valid_i = 1'b0;
    slv_b_ready_i = 1'b0;
  endtask

  // abort_after >= 0 returns right after that beat's handshake, leaving mst R driven.
  task automatic read_burst(input logic [63:0] addr, input int len, input int size,
                            input logic [1:0] burst, input logic [3:0] id, input int abort_after);
    ar_chan_t     exp_ar;
    logic [63:0]  a;
    logic [31:0]  words[8];
    logic [255:0] wide;
    r_exp_t       e, got;
    exp_ar = '0;
    exp_ar.id = id; exp_ar.addr = addr; exp_ar.len = 8'(len); exp_ar.size = 3'(size);
    exp_ar.burst = burst; exp_ar.prot = 3'h2;
    slv_ar_i = exp_ar;
    slv_ar_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({slv_ar_ready_o, mst_ar_valid_o} !== 2'b10) begin
      errors++; $display("FAIL ar_accept: ready/mst_valid got %b%b want 10", slv_ar_ready_o,
                         mst_ar_valid_o);
    end
    @(posedge clk); #1;
    slv_ar_valid_i = 1'b0;
    slv_ar_i = '0;
    @(negedge clk);
    checks++;
    if ({mst_ar_valid_o, mst_ar_o} !== {1'b1, exp_ar}) begin
      errors++; $display("FAIL mst_ar: got %b/%h want 1/%h", mst_ar_valid_o, mst_ar_o, exp_ar);
    end
    mst_ar_ready_i = 1'b1;
    @(posedge clk); #1;
    mst_ar_ready_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      for (int j = 0; j < 8; j++) begin
        words[j] = $urandom;
        wide[j*32 +: 32] = words[j];
      end
      e.data = words[a[4:2]];
      e.last = (i == len);
      e.id   = id;
      r_q.push_back(e);
      mst_r_i = '0;
      mst_r_i.id = id; mst_r_i.data = wide; mst_r_i.last = (i == len); mst_r_i.user = 8'(i);
      mst_r_valid_i = 1'b1;
      slv_r_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({slv_r_valid_o, mst_r_ready_o} !== 2'b11) begin
        errors++;
        $display("FAIL r_handshake beat %0d: got %b%b want 11", i, slv_r_valid_o, mst_r_ready_o);
      end
      got = {slv_r_o.data, slv_r_o.last, slv_r_o.id};
      e = r_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL r_beat %0d: got data=%h last=%b id=%h want data=%h last=%b id=%h", i,
                 got.data, got.last, got.id, e.data, e.last, e.id);
      end
      @(posedge clk); #1;
      if (i == abort_after) return;
    end
    mst_r_valid_i = 1'b0;
    slv_r_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (slv_ar_ready_o !== 1'b1) begin
      errors++; $display("FAIL ar_ready_after_last: got %b want 1", slv_ar_ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    slv_aw_i = '0; slv_ar_i = '0; slv_w_i = '0; mst_b_i = '0; mst_r_i = '0;
    slv_aw_valid_i = 1'b0; slv_ar_valid_i = 1'b0; slv_b_ready_i = 1'b0; slv_r_ready_i = 1'b0;
    mst_aw_ready_i = 1'b0; mst_ar_ready_i = 1'b0; mst_b_valid_i = 1'b0; mst_r_valid_i = 1'b1;
    slv_w_valid_i = 1'b1; mst_w_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({slv_aw_ready_o, slv_ar_ready_o} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: aw/ar got %b%b want 11", slv_aw_ready_o,
                         slv_ar_ready_o);
    end
    checks++;
    if ({mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o,
         slv_w_ready_o, mst_r_ready_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle: valids/readies got %b%b%b%b%b%b%b want 0000000", mst_aw_valid_o,
               mst_w_valid_o, mst_ar_valid_o, slv_b_valid_o, slv_r_valid_o, slv_w_ready_o,
               mst_r_ready_o);
    end
    slv_b_ready_i = 1'b1;
    #1;
    checks++;
    if (mst_b_ready_o !== 1'b1) begin
      errors++; $display("FAIL b_ready_follow: got %b want 1", mst_b_ready_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    slv_b_ready_i = 1'b0; mst_r_valid_i = 1'b0; slv_w_valid_i = 1'b0; mst_w_ready_i = 1'b0;
  endtask

  task automatic test_single_write();
    write_burst(64'h14, 0, 2, 2'b01, 4'h5, 0);
  endtask

  task automatic test_incr_write();
    write_burst(64'h18, 3, 2, 2'b01, 4'h2, 0);
  endtask

  task automatic test_wrap_read();
    read_burst(64'h08, 3, 2, 2'b10, 4'h6, -1);
  endtask

  task automatic test_fixed_read();
    read_burst(64'h1C, 1, 2, 2'b00, 4'h1, -1);
  endtask

  task automatic test_back_to_back();
    write_burst(64'h100, 1, 2, 2'b01, 4'h7, 0);
    write_burst(64'h204, 2, 2, 2'b01, 4'h8, 3);
  endtask

  task automatic test_reset_mid_read();
    read_burst(64'h40, 3, 2, 2'b01, 4'h3, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checks++;
    if ({slv_r_valid_o, mst_r_ready_o, mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o,
         slv_b_valid_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_read: valids got %b%b%b%b%b%b want 000000", slv_r_valid_o,
               mst_r_ready_o, mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, slv_b_valid_o);
    end
    mst_r_valid_i = 1'b0;
    slv_r_ready_i = 1'b0;
    #1;
    read_burst(64'h1C, 0, 2, 2'b01, 4'h9, -1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_write();
    test_wrap_read();
    test_fixed_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
